// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of a combinational 4-way ALU.
//   Buffers {sel, a, b, acc} commands in a FIFO, issues one at a time to the ALU through
//   registered operands, captures result and flags, and hands the result downstream over a
//   valid/ready handshake. A command with cmd_acc=1 takes operand A from the accumulator.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_ready = FIFO not full
//   cmd_sel, cmd_a, cmd_b, cmd_acc command payload
//   alu_a, alu_b, alu_sel         registered operands/opcode to the ALU
//   alu_out, alu_cf/of/zf         ALU result and flags (combinational from alu_*)
//   res_valid/res_ready           result handshake
//   res_data, res_cf/of/zf        captured result and flags
//   acc                           accumulator
//   busy                          FSM not idle
//   count                         FIFO occupancy
module alu_op_sequencer #(
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_sel,
   input  logic [W-1:0]               cmd_a,
   input  logic [W-1:0]               cmd_b,
   input  logic                       cmd_acc,
   output logic [W-1:0]               alu_a,
   output logic [W-1:0]               alu_b,
   output logic [2:0]                 alu_sel,
   input  logic [W-1:0]               alu_out,
   input  logic                       alu_cf,
   input  logic                       alu_of,
   input  logic                       alu_zf,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [W-1:0]               res_data,
   output logic                       res_cf,
   output logic                       res_of,
   output logic                       res_zf,
   output logic [W-1:0]               acc,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH+1);
   localparam int unsigned EntW = 2*W + 4;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   // FIFO storage, entry layout {sel, a, b, acc}
   logic [EntW-1:0] mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;

   state_e          state_q, state_d;
   logic [W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]      alu_sel_q, alu_sel_d;
   logic [W-1:0]    res_data_q, res_data_d, acc_q, acc_d;
   logic            res_valid_q, res_valid_d;
   logic            res_cf_q, res_cf_d, res_of_q, res_of_d, res_zf_q, res_zf_d;

   logic            push, pop;
   logic [EntW-1:0] head;
   logic [2:0]      head_sel;
   logic [W-1:0]    head_a, head_b;
   logic            head_acc;
   logic            is_arith, is_cmp;

   // A full FIFO refuses a push even if a pop happens in the same cycle (no bypass).
   assign cmd_ready = (count_q != CntW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;

   assign head     = mem_q[rd_ptr_q];
   assign head_sel = head[EntW-1 -: 3];
   assign head_a   = head[2*W -: W];
   assign head_b   = head[W -: W];
   assign head_acc = head[0];

   // Carry/overflow are only meaningful for add/sub; compares do not touch the accumulator.
   assign is_arith = (alu_sel_q[2:1] == 2'b00);
   assign is_cmp   = (alu_sel_q[2:1] == 2'b11);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_sel, cmd_a, cmd_b, cmd_acc};
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      res_data_d  = res_data_q;
      res_cf_d    = res_cf_q;
      res_of_d    = res_of_q;
      res_zf_d    = res_zf_q;
      res_valid_d = res_valid_q;
      acc_d       = acc_q;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop       = 1'b1;
               alu_a_d   = head_acc ? acc_q : head_a;
               alu_b_d   = head_b;
               alu_sel_d = head_sel;
               state_d   = StExec;
            end
         end
         StExec: begin
            res_data_d  = alu_out;
            res_zf_d    = alu_zf;
            res_cf_d    = is_arith & alu_cf;
            res_of_d    = is_arith & alu_of;
            res_valid_d = 1'b1;
            if (!is_cmp) begin
               acc_d = alu_out;
            end
            state_d = StResp;
         end
         StResp: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= StIdle;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         res_data_q  <= '0;
         res_cf_q    <= 1'b0;
         res_of_q    <= 1'b0;
         res_zf_q    <= 1'b0;
         res_valid_q <= 1'b0;
         acc_q       <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q     <= count_d;
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         res_data_q  <= res_data_d;
         res_cf_q    <= res_cf_d;
         res_of_q    <= res_of_d;
         res_zf_q    <= res_zf_d;
         res_valid_q <= res_valid_d;
         acc_q       <= acc_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_cf    = res_cf_q;
   assign res_of    = res_of_q;
   assign res_zf    = res_zf_q;
   assign acc       = acc_q;
   assign busy      = (state_q != StIdle);
   assign count     = count_q;

endmodule
